// File: rtl/modulo_receptor_uart.sv
// UART receiver: 2-flop line synchroniser, mid-bit sampling (LSB first), stop-bit
// check, registered one-cycle valid / framing-error strobes.
module modulo_receptor_uart #(
  parameter int CICLOS_DE_RELOJ_POR_BIT = 10417,
  parameter int CANTIDAD_BITS_RECEPCION = 8
) (
  input  logic                               reloj,
  input  logic                               reinicio,
  input  logic                               lineaRecepcionBits,
  output logic [CANTIDAD_BITS_RECEPCION-1:0] bitsRecibidos,
  output logic                               datoValido,
  output logic                               errorTrama,
  output logic                               ocupado
);

  localparam int N     = CANTIDAD_BITS_RECEPCION;
  localparam int CNT_W = $clog2(CICLOS_DE_RELOJ_POR_BIT);
  localparam int IDX_W = $clog2(N) + 1;
  localparam int MITAD = CICLOS_DE_RELOJ_POR_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_MITAD = CNT_W'(MITAD - 1);
  localparam logic [CNT_W-1:0] CNT_FIN   = CNT_W'(CICLOS_DE_RELOJ_POR_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_FIN   = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    ESPERA            = 3'd0,
    BIT_INICIO        = 3'd1,
    DATOS             = 3'd2,
    BIT_FINALIZACION  = 3'd3,
    ESPERA_LINEA_ALTA = 3'd4
  } estado_t;

  estado_t          state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [N-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      sync_q  <= 2'b11;
      state_q <= ESPERA;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], lineaRecepcionBits};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ESPERA: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = BIT_INICIO;
      end
      BIT_INICIO: begin
        // Recheck at mid start bit; a line already back high was a glitch.
        if (cnt_q == CNT_MITAD) begin
          cnt_d   = '0;
          state_d = rx_s ? ESPERA : DATOS;
        end
      end
      DATOS: begin
        if (cnt_q == CNT_FIN) begin
          cnt_d          = '0;
          shreg_d        = shreg_q >> 1;
          shreg_d[N-1]   = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_FIN) state_d = BIT_FINALIZACION;
        end
      end
      BIT_FINALIZACION: begin
        if (cnt_q == CNT_FIN) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = ESPERA;
          end else begin
            err_d   = 1'b1;
            state_d = ESPERA_LINEA_ALTA;
          end
        end
      end
      ESPERA_LINEA_ALTA: begin
        // A held-low line must not be mistaken for a new start bit.
        cnt_d = '0;
        if (rx_s) state_d = ESPERA;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ESPERA;
      end
    endcase
  end

  assign bitsRecibidos = data_q;
  assign datoValido    = valid_q;
  assign errorTrama    = err_q;
  assign ocupado       = (state_q != ESPERA);

endmodule

// File: doc/modulo_receptor_uart.md
# modulo_receptor_uart

Serial-to-parallel UART receiver: the stage at the far end of the serial line driven by the team's UART transmitter. It synchronises the incoming line, detects the start bit, samples each data bit at mid-bit (LSB first), checks the stop bit, and presents the received word with a one-cycle valid strobe or a one-cycle framing-error strobe. Frame format is 8N1 by default: one start bit (0), `CANTIDAD_BITS_RECEPCION` data bits, one stop bit (1), no parity.

## Interface
- `CICLOS_DE_RELOJ_POR_BIT`, 10417: clock cycles per bit period, ≥ 4.
- `CANTIDAD_BITS_RECEPCION`, 8: data bits per frame, ≥ 1.
- `reloj` input 1: single clock; all logic on its rising edge.
- `reinicio` input 1: reset, asynchronous assert, active-low.
- `lineaRecepcionBits` input 1: asynchronous serial line, idles high.
- `bitsRecibidos` output `CANTIDAD_BITS_RECEPCION`: last correctly framed word; holds until the next valid frame.
- `datoValido` output 1: one-cycle pulse; `bitsRecibidos` is new in the same cycle.
- `errorTrama` output 1: one-cycle pulse; stop bit sampled as 0.
- `ocupado` output 1: high in every state except ESPERA.

## Operation
- Input synchroniser: 2 flops; both reset to 1. All decisions use the second flop (`rx_s`).
- Counter width: `$clog2(CICLOS_DE_RELOJ_POR_BIT)`. `MITAD = CICLOS_DE_RELOJ_POR_BIT/2`, integer division. Bit index width: `$clog2(CANTIDAD_BITS_RECEPCION)+1`.
- States: ESPERA, BIT_INICIO, DATOS, BIT_FINALIZACION, ESPERA_LINEA_ALTA; 3-bit encoding. Unused encodings go to ESPERA.
- ESPERA: counter = 0, index = 0. If `rx_s == 0`, go to BIT_INICIO.
- BIT_INICIO: count up each cycle. When counter == `MITAD-1`:
  - If `rx_s == 0`, go to DATOS with counter = 0.
  - Otherwise the low was a glitch: go to ESPERA. No output.
- DATOS: count up. When counter == `CICLOS_DE_RELOJ_POR_BIT-1`:
  - Shift `rx_s` into the shift register MSB; the first sampled bit ends up at bit 0.
  - Counter = 0, index + 1.
  - After the `CANTIDAD_BITS_RECEPCION`-th sample, go to BIT_FINALIZACION.
- BIT_FINALIZACION: count up. When counter == `CICLOS_DE_RELOJ_POR_BIT-1`, sample `rx_s`:
  - If 1: register `bitsRecibidos` <= shift register, pulse `datoValido`, go to ESPERA.
  - If 0: pulse `errorTrama`, leave `bitsRecibidos` unchanged, go to ESPERA_LINEA_ALTA.
- ESPERA_LINEA_ALTA: stay while `rx_s == 0` (break/line fault). Go to ESPERA on the first cycle with `rx_s == 1`. No start detection in this state.
- `datoValido` and `errorTrama` are never high together.

## Timing
- Reset values: `bitsRecibidos` = 0, `datoValido` = 0, `errorTrama` = 0, `ocupado` = 0, state = ESPERA, counters = 0, synchroniser = 11.
- Reset asserted mid-frame aborts immediately; the partial frame is discarded and no strobe is generated.
- Input latency: 2 cycles from pin to `rx_s`.
- Sample points: every data and stop sample falls `MITAD` + k·`CICLOS_DE_RELOJ_POR_BIT` cycles after the cycle in which `rx_s` first reads 0 (k = 1..N+1, ±1 cycle).
- Strobe timing: `datoValido`/`errorTrama` are registered and high for exactly one cycle. They occur `MITAD + (N+1)·CICLOS_DE_RELOJ_POR_BIT + 3` cycles after the pin falling edge (±1).
- Back-to-back frames: a start bit that begins right after the stop-bit sample is accepted. The receiver is back in ESPERA about half a bit period before the stop bit ends.
- Tolerance: combined clock/baud error of up to ±4 % over a frame must still decode.

## Test plan
Use `CICLOS_DE_RELOJ_POR_BIT=16`, `CANTIDAD_BITS_RECEPCION=8`.
- Frame 0xA5 on the line, 16 cycles/bit -> one `datoValido` pulse, `bitsRecibidos`=0xA5, `errorTrama` stays 0, `ocupado` high during the frame.
- 4-cycle low glitch on an idle line -> no strobe; `bitsRecibidos` unchanged; state returns to ESPERA about 10 cycles after the glitch.
- Frame 0x3C with the stop bit forced to 0 for 40 cycles -> one `errorTrama` pulse, `bitsRecibidos` keeps its previous value, no start is detected until the line goes high.
- Frames 0x00 then 0xFF back-to-back, zero idle between them -> two `datoValido` pulses, values 0x00 then 0xFF.
- `reinicio` driven low during data bit 4 of frame 0x5A, then a full 0x81 frame sent -> no strobe for the aborted frame, all outputs 0 during reset, then `datoValido` with 0x81.
- Loopback from the team's UART transmitter, same bit period, 256 random bytes -> every byte received matches, zero `errorTrama` pulses.
